// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector: valid-qualified history shift register,
// Moore-timed match strobe, stretched match output and saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 HOLD        = 2,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0101),
  parameter int                 DEF_LEN     = 3,
  localparam int                LEN_W       = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count
);

  localparam int HOLD_W = $clog2(HOLD + 1);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len_raw);
    if (len_raw == '0) begin
      clamp_len = LEN_W'(1);
    end else if (len_raw > LEN_W'(MAX_LEN)) begin
      clamp_len = LEN_W'(MAX_LEN);
    end else begin
      clamp_len = len_raw;
    end
  endfunction

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               out_q, out_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] mask_s;
  logic [MAX_LEN-1:0] hist_shift_s;
  logic [LEN_W:0]     fill_inc_s;
  logic               full_s;
  logic               match_s;

  // Only the low len bits of history and pattern take part in the compare
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_q));
    end
  end

  // Match evaluation on the history as it will look after this edge's shift
  always_comb begin
    hist_shift_s = MAX_LEN'({hist_q, in});
    fill_inc_s   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    full_s       = (fill_inc_s >= {1'b0, len_q});
    match_s      = in_valid && full_s &&
                   ((hist_shift_s & mask_s) == (pattern_q & mask_s));
  end

  // Next-state: cfg_load overrides the data path and clears all match state
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    hold_d    = hold_q;
    out_d     = out_q;
    pulse_d   = 1'b0;
    count_d   = count_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = clamp_len(cfg_len);
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      hold_d    = '0;
      out_d     = 1'b0;
      count_d   = '0;
    end else begin
      if (in_valid) begin
        hist_d = hist_shift_s;
        if (match_s && !overlap_q) begin
          fill_d = '0;
        end else if (full_s) begin
          fill_d = len_q;
        end else begin
          fill_d = fill_inc_s[LEN_W-1:0];
        end
      end else begin
        hist_d = hist_q;
      end
      if (match_s) begin
        hold_d  = HOLD_W'(HOLD);
        out_d   = 1'b1;
        pulse_d = 1'b1;
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          count_d = count_q;
        end
      end else begin
        // out mirrors a nonzero hold count one cycle ahead of the decrement
        out_d  = (hold_q > HOLD_W'(1));
        hold_d = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
      end
    end
  end

  // State registers with asynchronous reset to the default configuration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= clamp_len(LEN_W'(DEF_LEN));
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      hold_q    <= '0;
      out_q     <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
    end
  end

  assign out         = out_q;
  assign match_pulse = pulse_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model (two DUTs: 8-bit and 2-bit counters).
module tb_seq_detect_param;
  localparam int MAX_LEN = 8;
  localparam int HOLD    = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_load;
  logic [7:0]       cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             in_valid;
  logic             in_bit;
  logic             out_a, pulse_a, out_c, pulse_c;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_c;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_since;
  int         m_cnt;
  bit         m_pulse;

  typedef struct {
    bit v;
    bit b;
    bit e_out;
    bit e_pulse;
    int e_cnt;
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .HOLD(HOLD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in_bit),
    .out(out_a), .match_pulse(pulse_a), .match_count(cnt_a));

  seq_detect_param #(.MAX_LEN(MAX_LEN), .HOLD(HOLD), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in_bit),
    .out(out_c), .match_pulse(pulse_c), .match_count(cnt_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit model_hit();
    if (mq.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (mq[mq.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pat = 8'h05; m_len = 3; m_ovl = 1'b1;
    mq.delete();
    m_since = 1000; m_cnt = 0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input logic [7:0] pat, input int len,
                            input bit ovl, input bit v, input bit b);
    m_pulse = 1'b0;
    if (m_since < 1000) m_since++;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
      m_ovl = ovl;
      mq.delete();
      m_since = 1000;
      m_cnt = 0;
    end else if (v) begin
      mq.push_back(b);
      if (model_hit()) begin
        m_pulse = 1'b1;
        m_since = 0;
        m_cnt++;
        if (!m_ovl) mq.delete();
      end
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
    end
  endtask

  task automatic check_all();
    chk("out", int'(out_a), int'(m_since < HOLD));
    chk("match_pulse", int'(pulse_a), int'(m_pulse));
    chk("match_count", int'(cnt_a), min_i(m_cnt, 255));
    chk("out_c", int'(out_c), int'(m_since < HOLD));
    chk("match_pulse_c", int'(pulse_c), int'(m_pulse));
    chk("match_count_c", int'(cnt_c), min_i(m_cnt, 3));
  endtask

  task automatic step(input bit ld, input logic [7:0] pat, input int len,
                      input bit ovl, input bit v, input bit b);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len);
    cfg_overlap = ovl; in_valid = v; in_bit = b;
    model_edge(ld, pat, len, ovl, v, b);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bits(input logic [7:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 8'h00, 0, 1'b0, 1'b1, val[i]);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3};

    reset = 1'b0; cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1 reset = 1'b1;

    // defaults (101, overlap, HOLD=2) including retrigger
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'h00, 0, 1'b0, tbl[i].v, tbl[i].b);
      chk("tbl_out", int'(out_a), int'(tbl[i].e_out));
      chk("tbl_pulse", int'(pulse_a), int'(tbl[i].e_pulse));
      chk("tbl_count", int'(cnt_a), tbl[i].e_cnt);
    end

    // non-overlapping 101 on 10101: a single match
    step(1'b1, 8'h05, 3, 1'b0, 1'b0, 1'b0);
    bits(8'b0001_0101, 5);
    chk("novl_count", int'(cnt_a), 1);
    step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);

    // 8-bit pattern with a three-cycle valid gap midway
    step(1'b1, 8'hCB, 8, 1'b1, 1'b0, 1'b0);
    bits(8'b0000_1100, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    chk("gap_nomatch", int'(cnt_a), 0);
    bits(8'b0000_1011, 4);
    chk("len8_pulse", int'(pulse_a), 1);
    chk("len8_count", int'(cnt_a), 1);

    // cfg_len=0 clamps to 1; the 2-bit counter saturates at 3
    step(1'b1, 8'h01, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1);
      chk("sat_pulse", int'(pulse_c), 1);
      chk("sat_count", int'(cnt_c), min_i(i + 1, 3));
    end
    step(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    chk("len1_zero_pulse", int'(pulse_a), 0);
    chk("len1_count", int'(cnt_a), 5);

    // cfg_len above MAX_LEN acts as MAX_LEN
    step(1'b1, 8'hA5, 11, 1'b1, 1'b0, 1'b0);
    bits(8'hA5, 8);
    chk("lenmax_pulse", int'(pulse_a), 1);

    // cfg_load on the edge that would complete a match wins
    step(1'b1, 8'h05, 3, 1'b1, 1'b0, 1'b0);
    bits(8'b0000_0010, 2);
    step(1'b1, 8'h05, 3, 1'b1, 1'b1, 1'b1);
    chk("load_win_pulse", int'(pulse_a), 0);
    chk("load_win_count", int'(cnt_a), 0);

    // async reset in the middle of an out hold
    bits(8'b0000_0101, 3);
    chk("pre_rst_out", int'(out_a), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out", int'(out_a), 0);
    chk("rst_pulse", int'(pulse_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    #2 reset = 1'b1;
    bits(8'b0000_0001, 2);
    chk("post_rst_nomatch", int'(cnt_a), 0);
    bits(8'b0000_0101, 3);
    chk("post_rst_count", int'(cnt_a), 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit ld, ovl, v, b;
      int len;
      logic [7:0] pat;
      ld  = ($urandom_range(0, 39) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(1, 4));
      ovl = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      step(ld, pat, len, ovl, v, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
